// File: rtl/ast_packet_arbiter.sv
// ast_packet_arbiter: merges IN_DIRS_CNT Avalon-ST packet streams into one
// registered output stream without interleaving beats of different packets.
// Selection is round-robin (ARB_MODE=0) or fixed priority, lowest index wins
// (ARB_MODE=1). The winning input index is carried on ast_source_channel_o.
// Optional per-input packet counters: define AST_PACKET_ARBITER_STATS_EN.
//
// Handshake: a beat moves across an interface on a rising clk_i edge where
// valid and ready are both high. Sink ready depends combinationally on sink
// valid (IDLE winner selection) and on ast_source_ready_i; source valid and
// payload come straight from flops and only change when the register loads.
module ast_packet_arbiter #(
    parameter int BYTE_W      = 8,
    parameter int IN_DIRS_CNT = 4,
    parameter int AST_SYMBOLS = 1,
    parameter int AST_EMPTY_W = (AST_SYMBOLS == 1) ? 1 : $clog2(AST_SYMBOLS),
    parameter int ARB_MODE    = 0,
    parameter int CHANNEL_W   = (IN_DIRS_CNT == 1) ? 1 : $clog2(IN_DIRS_CNT)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_n_i,
    input  logic [IN_DIRS_CNT*AST_SYMBOLS*BYTE_W-1:0] ast_sink_data_i,
    input  logic [IN_DIRS_CNT-1:0]                    ast_sink_valid_i,
    output logic [IN_DIRS_CNT-1:0]                    ast_sink_ready_o,
    input  logic [IN_DIRS_CNT*AST_EMPTY_W-1:0]        ast_sink_empty_i,
    input  logic [IN_DIRS_CNT-1:0]                    ast_sink_startofpacket_i,
    input  logic [IN_DIRS_CNT-1:0]                    ast_sink_endofpacket_i,
    output logic [AST_SYMBOLS*BYTE_W-1:0]             ast_source_data_o,
    output logic                                      ast_source_valid_o,
    input  logic                                      ast_source_ready_i,
    output logic [AST_EMPTY_W-1:0]                    ast_source_empty_o,
    output logic                                      ast_source_startofpacket_o,
    output logic                                      ast_source_endofpacket_o,
    output logic [CHANNEL_W-1:0]                      ast_source_channel_o
`ifdef AST_PACKET_ARBITER_STATS_EN
    ,
    input  logic                                      stats_clear_i,
    output logic [IN_DIRS_CNT*32-1:0]                 stats_pkt_cnt_o
`endif
);

    localparam int DATA_W = AST_SYMBOLS * BYTE_W;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CHANNEL_W-1:0]   grant_q, grant_d;
    logic [CHANNEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic                   run_q;

    logic [DATA_W-1:0]      src_data_q, src_data_d;
    logic                   src_valid_q, src_valid_d;
    logic [AST_EMPTY_W-1:0] src_empty_q, src_empty_d;
    logic                   src_sop_q, src_sop_d;
    logic                   src_eop_q, src_eop_d;
    logic [CHANNEL_W-1:0]   src_chan_q, src_chan_d;

    logic                   can_load;
    logic                   sel_found;
    logic [CHANNEL_W-1:0]   sel_idx;
    logic                   cur_active;
    logic [CHANNEL_W-1:0]   cur_grant;
    logic [DATA_W-1:0]      cur_data;
    logic [AST_EMPTY_W-1:0] cur_empty;
    logic                   cur_valid;
    logic                   cur_sop;
    logic                   cur_eop;
    logic                   accept;

    assign can_load = !src_valid_q || ast_source_ready_i;

    // Pick the IDLE winner: scan upward from the pointer (or from 0 for fixed priority).
    always_comb begin : sel_proc
        logic [CHANNEL_W-1:0] idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = '0;
        for (int k = 0; k < IN_DIRS_CNT; k++) begin
            if (ARB_MODE == 1) begin
                idx = CHANNEL_W'(k);
            end else begin
                idx = CHANNEL_W'((int'(rr_ptr_q) + k) % IN_DIRS_CNT);
            end
            if (!sel_found && ast_sink_valid_i[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    assign cur_active = (state_q == ST_LOCKED) || sel_found;
    assign cur_grant  = (state_q == ST_LOCKED) ? grant_q : sel_idx;

    // Route the currently granted input's beat and drive ready only to it.
    always_comb begin
        cur_data         = '0;
        cur_empty        = '0;
        cur_valid        = 1'b0;
        cur_sop          = 1'b0;
        cur_eop          = 1'b0;
        ast_sink_ready_o = '0;
        for (int i = 0; i < IN_DIRS_CNT; i++) begin
            if (cur_grant == CHANNEL_W'(i)) begin
                cur_data  = ast_sink_data_i[i*DATA_W +: DATA_W];
                cur_empty = ast_sink_empty_i[i*AST_EMPTY_W +: AST_EMPTY_W];
                cur_valid = ast_sink_valid_i[i];
                cur_sop   = ast_sink_startofpacket_i[i];
                cur_eop   = ast_sink_endofpacket_i[i];
                ast_sink_ready_o[i] = run_q && can_load && cur_active;
            end
        end
    end

    assign accept = run_q && can_load && cur_active && cur_valid;

    // Grant FSM: lock onto a packet at its first accepted beat, release at its EOP.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (cur_eop) begin
                state_d  = ST_IDLE;
                rr_ptr_d = CHANNEL_W'((int'(cur_grant) + 1) % IN_DIRS_CNT);
            end else begin
                state_d  = ST_LOCKED;
                grant_d  = cur_grant;
            end
        end
    end

    // Output register: load on acceptance, drop valid once the held beat drains.
    always_comb begin
        src_data_d  = src_data_q;
        src_valid_d = src_valid_q;
        src_empty_d = src_empty_q;
        src_sop_d   = src_sop_q;
        src_eop_d   = src_eop_q;
        src_chan_d  = src_chan_q;
        if (can_load) begin
            src_valid_d = accept;
            if (accept) begin
                src_data_d  = cur_data;
                src_empty_d = cur_empty;
                src_sop_d   = cur_sop;
                src_eop_d   = cur_eop;
                src_chan_d  = cur_grant;
            end
        end
    end

    // State, pointer and output flops; run_q holds everything off until the first edge after reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            run_q       <= 1'b0;
            src_data_q  <= '0;
            src_valid_q <= 1'b0;
            src_empty_q <= '0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            src_chan_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            run_q       <= 1'b1;
            src_data_q  <= src_data_d;
            src_valid_q <= src_valid_d;
            src_empty_q <= src_empty_d;
            src_sop_q   <= src_sop_d;
            src_eop_q   <= src_eop_d;
            src_chan_q  <= src_chan_d;
        end
    end

    assign ast_source_data_o          = src_data_q;
    assign ast_source_valid_o         = src_valid_q;
    assign ast_source_empty_o         = src_empty_q;
    assign ast_source_startofpacket_o = src_sop_q;
    assign ast_source_endofpacket_o   = src_eop_q;
    assign ast_source_channel_o       = src_chan_q;

`ifdef AST_PACKET_ARBITER_STATS_EN
    logic [IN_DIRS_CNT*32-1:0] pkt_cnt_q, pkt_cnt_d;

    // Per-input saturating packet counters; clear beats a same-cycle increment.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        for (int i = 0; i < IN_DIRS_CNT; i++) begin
            if (stats_clear_i) begin
                pkt_cnt_d[i*32 +: 32] = '0;
            end else if (accept && cur_eop && (cur_grant == CHANNEL_W'(i)) &&
                         (pkt_cnt_q[i*32 +: 32] != 32'hFFFF_FFFF)) begin
                pkt_cnt_d[i*32 +: 32] = pkt_cnt_q[i*32 +: 32] + 32'd1;
            end
        end
    end

    // Counter flops.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign stats_pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: doc/ast_packet_arbiter.md
Name: ast_packet_arbiter

Overview:
- N-input Avalon-ST packet arbiter: merges IN_DIRS_CNT packet streams into one output stream without interleaving beats of different packets.
- Grant is held from the first accepted beat of a packet to its EOP beat; selection policy is round-robin or fixed priority.
- Output is registered and carries the winning input's index on a channel sideband.
- Used as the next-generation merge stage after the per-string-size FIFOs in the string extraction path (single clock domain).

Parameters:
- BYTE_W, 8, bits per symbol
- IN_DIRS_CNT, 4, number of sink inputs (>=2)
- AST_SYMBOLS, 1, symbols per beat
- AST_EMPTY_W, (AST_SYMBOLS==1) ? 1 : $clog2(AST_SYMBOLS), empty field width
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
- CHANNEL_W, (IN_DIRS_CNT==1) ? 1 : $clog2(IN_DIRS_CNT), channel field width

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous reset, active low
- ast_sink_data_i  in  IN_DIRS_CNT*AST_SYMBOLS*BYTE_W  per-input data
- ast_sink_valid_i  in  IN_DIRS_CNT  per-input valid
- ast_sink_ready_o  out  IN_DIRS_CNT  per-input ready
- ast_sink_empty_i  in  IN_DIRS_CNT*AST_EMPTY_W  per-input empty
- ast_sink_startofpacket_i  in  IN_DIRS_CNT  per-input SOP
- ast_sink_endofpacket_i  in  IN_DIRS_CNT  per-input EOP
- ast_source_data_o  out  AST_SYMBOLS*BYTE_W  merged data
- ast_source_valid_o  out  1  merged valid
- ast_source_ready_i  in  1  downstream ready
- ast_source_empty_o  out  AST_EMPTY_W  merged empty
- ast_source_startofpacket_o  out  1  merged SOP
- ast_source_endofpacket_o  out  1  merged EOP
- ast_source_channel_o  out  CHANNEL_W  index of the input that produced the beat

Behaviour:
- Reset: all source outputs 0, ast_sink_ready_o 0, FSM in IDLE, round-robin pointer 0. Asynchronous assertion; internal logic released on the first clk_i edge after deassertion.
- Output register:
  - can_load = !ast_source_valid_o || ast_source_ready_i.
  - A sink beat is accepted when ast_sink_valid_i[g] && ast_sink_ready_o[g].
  - An accepted beat loads the output register the same edge, giving 1-cycle latency.
  - Full throughput: one beat per cycle when downstream holds ready high.
- ast_sink_ready_o[i] = can_load && (i == current grant). Non-granted inputs always see ready 0. In IDLE, ready is driven only to the combinationally selected winner.
- FSM states:
  - IDLE: select a winner among valid inputs. Round-robin searches from the pointer upward with wrap-around; fixed priority takes the lowest valid index. If the winner's first beat is accepted with EOP=1 (single-beat packet), stay in IDLE; otherwise latch grant g and go to LOCKED.
  - LOCKED: only input g is served; return to IDLE on acceptance of a beat from g with EOP=1. Other inputs' valid is ignored.
- Round-robin pointer updates to (g+1) mod IN_DIRS_CNT on acceptance of g's EOP beat. The pointer is unused when ARB_MODE=1.
- SOP is not used for arbitration. The first accepted beat after IDLE opens the grant regardless of SOP. SOP/EOP/empty are forwarded unchanged.
- No valid inputs in IDLE: no grant, all ready 0, output register drains normally.
- Downstream backpressure mid-packet: grant held, register holds its value, ready to g is 0.
- Granted input drops valid mid-packet: grant held indefinitely until its EOP; no timeout.
- Reset mid-packet: FSM returns to IDLE and the output beat is discarded; no EOP is synthesised.

Optional Feature:
- Macro AST_PACKET_ARBITER_STATS_EN.
- When defined, adds ports stats_clear_i (in, 1) and stats_pkt_cnt_o (out, IN_DIRS_CNT*32).
- stats_pkt_cnt_o holds one 32-bit counter per input, incremented on acceptance of that input's EOP beat.
- Counters saturate at 32'hFFFF_FFFF, reset to 0, and are cleared synchronously by stats_clear_i; clear wins over a simultaneous increment.
- When the macro is not defined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- IN_DIRS_CNT=4, ARB_MODE=0, all inputs continuously offering 3-beat packets, ready=1 -> output channel sequence 0,0,0,1,1,1,2,2,2,3,3,3,0…; no gaps; SOP on the first beat and EOP on the third of each group.
- ARB_MODE=1, inputs 1 and 3 valid with 2-beat packets -> channel 1 served repeatedly; input 3 starves while input 1 stays valid.
- Input 2 mid-packet (beat 2 of 4), input 0 asserts valid -> input 0 ready stays 0 until input 2's EOP is accepted; the next packet goes to input 3 if it is valid, otherwise to input 0.
- Single-beat packets (SOP=EOP=1) on inputs 0 and 1, round-robin -> alternating channels 0,1,0,1 at one beat per cycle.
- ast_source_ready_i toggles 1,0,0,1 during a 4-beat packet -> the output beat is stable while ready is 0, no beat is lost or duplicated, and the data order matches the input.
- Stats enabled: 5 packets on input 1, then stats_clear_i asserted together with a 6th EOP -> count reads 5, then 0 after the clear.
